// File: rtl/sng_pkg.sv
// Shared definitions for the bipolar stochastic-number stream generator:
// default sizes, controller state encoding and LFSR feedback taps.
package sng_pkg;

    localparam int SNG_LANES = 4;
    localparam int SNG_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sng_state_e;

    // x^4 + x^3 + 1: feedback is the parity of state bits 3 and 2
    localparam logic [3:0] SNG_TAP_MASK = 4'b1100;

    // Maximal-length Fibonacci tap masks for other widths, so WIDTH can be
    // overridden without losing the full 2^WIDTH-1 period.
    function automatic logic [15:0] sng_taps(input int w);
        case (w)
            3:       return 16'h0006;
            4:       return {12'h000, SNG_TAP_MASK};
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            default: return {12'h000, SNG_TAP_MASK};
        endcase
    endfunction

endpackage

// File: rtl/sng_lfsr.sv
// Fibonacci LFSR supplying the per-bit random value. Load has priority
// over advance; a loaded non-zero seed keeps the sequence away from 0.
module sng_lfsr
    import sng_pkg::*;
#(
    parameter int WIDTH = SNG_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic             advance_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [WIDTH-1:0] state_o
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(sng_taps(WIDTH));

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    // Next state: reload from seed, shift in the tap parity, or hold
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (advance_i) begin
            state_d = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
        end
    end

    // State register with synchronous active-low clear
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/sn_stream_gen.sv
// Bipolar stochastic-number stream generator. A start in IDLE latches the
// lane values, length and seed, then emits len+1 valid cycles of one bit
// per lane (bit = offset-binary lane value > random value), followed by a
// one-cycle done pulse.
// Build option SNG_DECORR_EN: lane k compares against the LFSR state rotated
// left by k mod WIDTH, decorrelating lanes; without it all lanes share the
// unrotated state. Timing and full-period ones-counts are the same either way.
//
// state | meaning
// IDLE  | waiting for start; outputs low
// RUN   | one stream bit per cycle, LFSR advances each cycle
// DONE  | single cycle with done pulse, start ignored
module sn_stream_gen
    import sng_pkg::*;
#(
    parameter int LANES = SNG_LANES,
    parameter int WIDTH = SNG_WIDTH
) (
    input  logic                   i_clk_sng,
    input  logic                   i_rst_n_sng,
    input  logic                   i_start_sng,
    input  logic [LANES*WIDTH-1:0] i_x_sng,
    input  logic [WIDTH-1:0]       i_len_sng,
    input  logic [WIDTH-1:0]       i_seed_sng,
    output logic                   o_busy_sng,
    output logic                   o_valid_sng,
    output logic [LANES-1:0]       o_sn_bit_sng,
    output logic                   o_done_sng
);

    sng_state_e             state_q;
    logic [LANES*WIDTH-1:0] x_q;
    logic [WIDTH-1:0]       cnt_q;
    logic                   busy_q;
    logic                   valid_q;
    logic                   done_q;

    logic                   lfsr_load;
    logic                   lfsr_advance;
    logic [WIDTH-1:0]       lfsr_state;
    logic [WIDTH-1:0]       seed_eff;

    // A zero seed would lock the LFSR at 0, so it is promoted to 1
    assign seed_eff     = (i_seed_sng == '0) ? WIDTH'(1) : i_seed_sng;
    assign lfsr_load    = (state_q == IDLE) && i_start_sng;
    assign lfsr_advance = (state_q == RUN);

    sng_lfsr #(
        .WIDTH (WIDTH)
    ) u_lfsr (
        .clk_i     (i_clk_sng),
        .rst_n_i   (i_rst_n_sng),
        .load_i    (lfsr_load),
        .advance_i (lfsr_advance),
        .seed_i    (seed_eff),
        .state_o   (lfsr_state)
    );

    // Flipping the sign bit turns two's complement into offset binary (x + 2^(W-1))
    function automatic logic [LANES-1:0] stream_bits(
        input logic [LANES*WIDTH-1:0] xv,
        input logic [WIDTH-1:0]       s
    );
        logic [LANES-1:0] b;
        logic [WIDTH-1:0] u;
        logic [WIDTH-1:0] r;
`ifdef SNG_DECORR_EN
        logic [2*WIDTH-1:0] dbl;
`endif
        b = '0;
        for (int k = 0; k < LANES; k++) begin
            u = xv[k*WIDTH +: WIDTH] ^ {1'b1, {(WIDTH-1){1'b0}}};
`ifdef SNG_DECORR_EN
            dbl = {s, s} << (k % WIDTH);
            r   = dbl[2*WIDTH-1:WIDTH];
`else
            r   = s;
`endif
            b[k] = (u > r);
        end
        return b;
    endfunction

    // Controller: start latching, bit counting and registered status outputs
    always_ff @(posedge i_clk_sng) begin
        if (!i_rst_n_sng) begin
            state_q <= IDLE;
            x_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (i_start_sng) begin
                        state_q <= RUN;
                        x_q     <= i_x_sng;
                        cnt_q   <= i_len_sng;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy_sng   = busy_q;
    assign o_valid_sng  = valid_q;
    assign o_done_sng   = done_q;
    // LFSR holds the random value of the bit currently on the outputs
    assign o_sn_bit_sng = valid_q ? stream_bits(x_q, lfsr_state) : '0;

endmodule

// File: tb/tb_sn_stream_gen.sv
// Scoreboard bench for sn_stream_gen: stimulus pushes model-predicted bits,
// a negedge monitor pops and compares whenever a valid bit or done appears.
// Define SNG_DECORR_EN for both RTL and bench to exercise the rotated build.
module tb_sn_stream_gen;

    localparam int L = 4;
    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           start;
    logic [L*W-1:0] x;
    logic [W-1:0]   len;
    logic [W-1:0]   seed;
    logic           busy;
    logic           valid;
    logic [L-1:0]   sn;
    logic           done;

    sn_stream_gen #(
        .LANES (L),
        .WIDTH (W)
    ) dut (
        .i_clk_sng    (clk),
        .i_rst_n_sng  (rst_n),
        .i_start_sng  (start),
        .i_x_sng      (x),
        .i_len_sng    (len),
        .i_seed_sng   (seed),
        .o_busy_sng   (busy),
        .o_valid_sng  (valid),
        .o_sn_bit_sng (sn),
        .o_done_sng   (done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [L-1:0] exp_q[$];
    int           done_q[$];
    logic [L-1:0] cap[$];
    logic [L-1:0] cap0[$];
    logic [L-1:0] e;
    int           vcnt;
    int           done_cnt;
    int           ones[L];
    int           net[L];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: maximal-length sequence of x^4+x^3+1 and offset-binary compare
    function automatic int lfsr_step(input int s);
        int fb;
        fb = ((s >> 3) ^ (s >> 2)) & 1;
        return ((s << 1) | fb) & 15;
    endfunction

    function automatic int lane_rand(input int s, input int k);
`ifdef SNG_DECORR_EN
        int sh;
        sh = k % W;
        return ((s << sh) | (s >> (W - sh))) & 15;
`else
        return s + 0 * k;
`endif
    endfunction

    task automatic push_stream(input logic [L*W-1:0] xv, input int ln, input int sd);
        int s;
        int u;
        logic [L-1:0] b;
        s = (sd == 0) ? 1 : sd;
        for (int i = 0; i <= ln; i++) begin
            for (int k = 0; k < L; k++) begin
                u = int'($signed(xv[k*W +: W])) + 8;
                b[k] = (u > lane_rand(s, k));
            end
            exp_q.push_back(b);
            s = lfsr_step(s);
        end
        done_q.push_back(1);
    endtask

    task automatic clear_stats();
        vcnt     = 0;
        done_cnt = 0;
        cap.delete();
        for (int k = 0; k < L; k++) begin
            ones[k] = 0;
            net[k]  = 0;
        end
    endtask

    task automatic start_stream(input logic [L*W-1:0] xv, input int ln, input int sd);
        @(posedge clk);
        #1;
        clear_stats();
        x     = xv;
        len   = ln[W-1:0];
        seed  = sd[W-1:0];
        start = 1'b1;
        push_stream(xv, ln, sd);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done_cnt == 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("done_timeout", (t >= 200) ? 1 : 0, 0);
    endtask

    // Monitor: compare every presented bit and done pulse against the scoreboard
    always @(negedge clk) begin
        if (valid) begin
            if (exp_q.size() == 0) begin
                chk("stream_overrun", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("sn_bits", sn, e);
            end
            cap.push_back(sn);
            vcnt++;
            for (int k = 0; k < L; k++) begin
                ones[k] += sn[k] ? 1 : 0;
                net[k]  += sn[k] ? 1 : -1;
            end
        end else begin
            chk("sn_zero_when_not_valid", sn, 0);
        end
        if (done) begin
            chk("done_with_valid", valid, 0);
            chk("done_expected", (done_q.size() == 0) ? 1 : 0, 0);
            if (done_q.size() > 0) void'(done_q.pop_front());
            chk("bits_left_at_done", exp_q.size(), 0);
            done_cnt++;
        end
    end

    initial begin
        logic [L*W-1:0] xr;
        int ln;
        int sd;
        int t;

        rst_n = 1'b0;
        start = 1'b0;
        x     = '0;
        len   = '0;
        seed  = '0;
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_valid", valid, 0);
        chk("reset_sn", sn, 0);
        chk("reset_done", done, 0);
        rst_n = 1'b1;

        // Lanes -8, 0, 3, 7 over a full period
        start_stream(16'h7308, 14, 1);
        wait_done();
        chk("full_valid_count", vcnt, 15);
        chk("ones_lane0", ones[0], 0);
        chk("ones_lane1", ones[1], 7);
        chk("ones_lane2", ones[2], 10);
        chk("ones_lane3", ones[3], 14);
        chk("full_done_count", done_cnt, 1);
        chk("full_idle_after", busy, 0);

        // Single-bit stream timing
        start_stream(16'($urandom), 0, int'($urandom_range(0, 15)));
        chk("len0_valid", valid, 1);
        chk("len0_busy", busy, 1);
        @(posedge clk);
        #1;
        chk("len0_valid_after", valid, 0);
        chk("len0_done", done, 1);
        chk("len0_busy_in_done", busy, 1);
        @(posedge clk);
        #1;
        chk("len0_done_clear", done, 0);
        chk("len0_idle", busy, 0);
        chk("len0_valid_count", vcnt, 1);

        // Zero seed behaves as seed 1
        xr = 16'($urandom);
        start_stream(xr, 14, 0);
        wait_done();
        cap0 = cap;
        start_stream(xr, 14, 1);
        wait_done();
        chk("seed0_len", cap.size(), cap0.size());
        for (int i = 0; i < cap.size() && i < cap0.size(); i++) begin
            chk("seed0_bit", cap0[i], cap[i]);
        end

        // Starts during RUN and DONE are ignored
        xr = 16'($urandom);
        start_stream(xr, 9, 5);
        repeat (4) @(posedge clk);
        #1;
        x     = ~xr;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t = 0;
        while (!done && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("ign_reach_done", done, 1);
        x     = 16'($urandom);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("ign_done_start_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("ign_no_new_stream", valid, 0);
        chk("ign_valid_count", vcnt, 10);
        chk("ign_done_count", done_cnt, 1);

        // Reset at the 5th valid bit aborts; restart on first edge after release
        start_stream(16'($urandom), 10, int'($urandom_range(1, 15)));
        repeat (4) @(posedge clk);
        #1;
        chk("abort_5th_valid", valid, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        done_q.delete();
        chk("abort_busy", busy, 0);
        chk("abort_valid", valid, 0);
        chk("abort_sn", sn, 0);
        chk("abort_done", done, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, 0);
        clear_stats();
        xr    = 16'($urandom);
        ln    = int'($urandom_range(2, 15));
        sd    = int'($urandom_range(0, 15));
        x     = xr;
        len   = ln[W-1:0];
        seed  = sd[W-1:0];
        rst_n = 1'b1;
        start = 1'b1;
        push_stream(xr, ln, sd);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("restart_valid", valid, 1);
        chk("restart_busy", busy, 1);
        wait_done();
        chk("restart_valid_count", vcnt, ln + 1);
        chk("restart_done_count", done_cnt, 1);

        // Zero-valued lanes into an up/down counter: 7 ups, 8 downs
        start_stream(16'h0000, 14, int'($urandom_range(1, 15)));
        wait_done();
        for (int k = 0; k < L; k++) begin
            chk("updown_net", net[k], -1);
        end

        // Randomized streams against the model
        repeat (8) begin
            xr = 16'($urandom);
            ln = int'($urandom_range(0, 15));
            sd = int'($urandom_range(0, 15));
            start_stream(xr, ln, sd);
            wait_done();
            chk("rand_valid_count", vcnt, ln + 1);
            chk("rand_done_count", done_cnt, 1);
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sn_stream_gen.md
SN_STREAM_GEN -- requirements
Module: sn_stream_gen

Interface
REQ-001 SHALL have parameter LANES, default 4, number of parallel bipolar stochastic lanes.
REQ-002 SHALL have parameter WIDTH, default 4, bit width of signed lane values, seed and length.
REQ-003 SHALL have port i_clk_sng  input  1  the only clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst_n_sng  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port i_start_sng  input  1  one-cycle request to begin a stream.
REQ-006 SHALL have port i_x_sng  input  LANES x WIDTH  signed two's-complement lane values, -8..7 at WIDTH=4.
REQ-007 SHALL have port i_len_sng  input  WIDTH  stream length minus one; length = i_len_sng+1 bits, 1..16.
REQ-008 SHALL have port i_seed_sng  input  WIDTH  LFSR seed.
REQ-009 SHALL have port o_busy_sng  output  1  high in RUN and DONE.
REQ-010 SHALL have port o_valid_sng  output  1  high on every cycle that carries a stream bit.
REQ-011 SHALL have port o_sn_bit_sng  output  LANES  one stochastic bit per lane.
REQ-012 SHALL have port o_done_sng  output  1  one-cycle pulse after the last stream bit.

Function
REQ-013 SHALL implement the states IDLE, RUN and DONE; IDLE->RUN on i_start_sng, RUN->DONE after the last bit, DONE->IDLE unconditionally after one cycle.
REQ-014 SHALL accept i_start_sng only in IDLE and ignore it in RUN and DONE, including the DONE cycle.
REQ-015 SHALL, on an accepted start, latch i_x_sng, i_len_sng and i_seed_sng, replacing a zero seed with 1; later input changes have no effect on the running stream.
REQ-016 SHALL, for a start accepted at edge N, assert o_valid_sng for exactly len+1 consecutive cycles beginning the cycle after edge N, then assert o_done_sng for one cycle with o_valid_sng low.
REQ-017 SHALL compute each lane bit as (u > r): u = x + 2^(WIDTH-1) as unsigned WIDTH bits, r = that lane's random value.
REQ-018 SHALL generate r from a WIDTH-bit maximal-length Fibonacci LFSR (x^4+x^3+1 at WIDTH=4) that starts at the latched seed, covers 1..15 and never reaches 0.
REQ-019 SHALL advance the LFSR once per valid bit; the LFSR period (15) wraps freely when length is 16.
REQ-020 SHALL drive o_sn_bit_sng to all zeros whenever o_valid_sng is low.
REQ-021 SHALL make x = -8 produce all-zero bits and x = 7 produce a one on every bit except the one where r = 15.

Reset
REQ-022 SHALL, while i_rst_n_sng is low at a clock edge, enter IDLE and clear the LFSR, the latched values, o_busy_sng, o_valid_sng, o_sn_bit_sng and o_done_sng to 0.
REQ-023 SHALL treat a reset during RUN or DONE as an abort: no o_done_sng pulse, outputs 0 from the next edge, and a new start accepted on the first edge after release.

Configuration
REQ-024 SHALL, with SNG_DECORR_EN defined, give lane k the LFSR state rotated left by k mod WIDTH bits, so lanes are decorrelated.
REQ-025 SHALL, without SNG_DECORR_EN, give every lane the unrotated LFSR state; cycle timing and per-lane ones-counts over a full 15-bit period are identical in both builds.

Structure
REQ-026 SHALL place LANES and WIDTH defaults, the state enum (IDLE, RUN, DONE) and the LFSR tap mask in shared package sng_pkg.
REQ-027 SHALL implement the LFSR as sub-module sng_lfsr, with load, advance and state ports, instantiated once.

Verification
REQ-028 SHALL cover: x={-8,0,3,7}, len=14, seed=1 -> exactly 15 valid cycles; ones-counts {0,7,10,14}; one o_done_sng pulse; test in both macro builds.
REQ-029 SHALL cover: len=0 -> exactly one valid cycle, o_done_sng on the next cycle, back in IDLE the cycle after.
REQ-030 SHALL cover: seed=0 -> stream identical to seed=1.
REQ-031 SHALL cover: i_start_sng pulsed mid-RUN and in DONE, with i_x_sng changed -> ignored, original stream unchanged.
REQ-032 SHALL cover: i_rst_n_sng low at the 5th valid bit -> all outputs 0 next edge, no o_done_sng; a restart after release runs normally.
REQ-033 SHALL cover: a stream fed into an up/down counter, len=14, x=0 -> net count -1 (7 ups, 8 downs).
